fab_clk_gen: RTL

Parametrised multi-channel fabric clock generator driven from the fabric clock out of the MSS clock conditioning circuit. Each channel divides FAB_CLK by a runtime-programmable ratio and produces a one-cycle clock-enable strobe plus a registered ~50% divided clock. Ratio updates are applied only at a channel's period boundary, so no runt strobe or runt pulse is ever produced. A LOCK indication covers reset and reconfiguration settling. Fabric logic uses this block in place of fixed CCC output dividers.

---
 rtl/fab_clk_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fab_clk_gen.sv
// fab_clk_gen: multi-channel fabric clock generator.
// Each channel divides FAB_CLK by R = div + 1 and produces a one-cycle
// strobe (CLK_EN) and a registered ~50% divided clock (CLK_OUT).
// Optional build macro: FAB_CLK_GEN_LOCK_EN (lock counter for LOCK).
//
// Write handshake: DIV_WR acts as valid and !DIV_BUSY as ready. A write is
// taken on a rising edge where DIV_WR=1, DIV_BUSY=0 and DIV_SEL<CHANNELS.
// Writes presented while DIV_BUSY=1, or with an out-of-range DIV_SEL, are
// dropped rather than queued. DIV_BUSY is the update FSM state itself
// (IDLE=0, PENDING=1) and stays high until the target channel reaches its
// old terminal count, where the new divide value is applied.
module fab_clk_gen #(
    parameter int CHANNELS    = 3,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3,
    parameter int LOCK_CYCLES = 16,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                FAB_CLK,
    input  logic                MSS_RESET_N,
    input  logic                DIV_WR,
    input  logic [SEL_W-1:0]    DIV_SEL,
    input  logic [DIV_W-1:0]    DIV_DATA,
    output logic                DIV_BUSY,
    output logic [CHANNELS-1:0] CLK_EN,
    output logic [CHANNELS-1:0] CLK_OUT,
    output logic                LOCK
);

    typedef enum logic {
        UPD_IDLE    = 1'b0,
        UPD_PENDING = 1'b1
    } upd_state_t;

    localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(CHANNELS);
    localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(DEFAULT_DIV);

    upd_state_t          state_q;
    upd_state_t          state_d;
    logic [SEL_W-1:0]    pend_sel_q;
    logic [DIV_W-1:0]    pend_div_q;
    logic [CHANNELS-1:0] apply_vec;
    logic                accept;
    logic                apply;

    assign accept   = DIV_WR && (state_q == UPD_IDLE) && ({1'b0, DIV_SEL} < SEL_LIMIT);
    assign apply    = |apply_vec;
    assign DIV_BUSY = (state_q == UPD_PENDING);

    // Update FSM state register.
    always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            state_q <= UPD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Update FSM next state: accept moves to PENDING, apply returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UPD_IDLE:    if (accept) state_d = UPD_PENDING;
            UPD_PENDING: if (apply)  state_d = UPD_IDLE;
            default:     state_d = UPD_IDLE;
        endcase
    end

    // Capture the pending target and value; first accepted write wins.
    always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            pend_sel_q <= '0;
            pend_div_q <= '0;
        end else if (accept) begin
            pend_sel_q <= DIV_SEL;
            pend_div_q <= DIV_DATA;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] cnt_next;
        logic [DIV_W-1:0] half;
        logic             en_q;
        logic             out_q;

        // Terminal count wraps to 0; an apply lands on the same wrap, so the
        // boundary strobe is kept and the new ratio starts at count 0.
        assign cnt_next     = (cnt_q == div_q) ? '0 : cnt_q + DIV_W'(1);
        // ceil(R/2) with R = div + 1.
        assign half         = (div_q >> 1) + DIV_W'(1);
        assign apply_vec[i] = DIV_BUSY && (pend_sel_q == SEL_W'(i)) && (cnt_q == div_q);
        assign CLK_EN[i]    = en_q;
        assign CLK_OUT[i]   = out_q;

        // Per-channel counter, divide register and registered outputs.
        always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
            if (!MSS_RESET_N) begin
                cnt_q <= '0;
                div_q <= DEF_DIV;
                en_q  <= 1'b0;
                out_q <= 1'b0;
            end else begin
                cnt_q <= cnt_next;
                if (apply_vec[i]) begin
                    div_q <= pend_div_q;
                end
                en_q  <= (cnt_next == '0);
                out_q <= (cnt_next < half);
            end
        end
    end

`ifdef FAB_CLK_GEN_LOCK_EN
    localparam int             LCW      = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);

    logic [LCW-1:0] lock_cnt_q;
    logic [LCW-1:0] lock_cnt_d;

    // Settling counter: cleared by an accepted write, held at 0 while busy,
    // otherwise counts up and saturates at LOCK_CYCLES.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (accept || DIV_BUSY) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
        end
    end

    // Lock counter register and registered LOCK flag.
    always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            lock_cnt_q <= '0;
            LOCK       <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            LOCK       <= (lock_cnt_d == LOCK_MAX);
        end
    end
`else
    // Without the lock counter, LOCK rises on the first edge after reset.
    always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            LOCK <= 1'b0;
        end else begin
            LOCK <= 1'b1;
        end
    end
`endif

endmodule
